sorter_scheduler: RTL and testbench

- Shares one Sorter instance (WID-bit insertion sorter, DEP cells, CLK/RST/DIN/VALID/DO/N_CELLS) between NREQ frame-based requesters, e.g. per-fiber sample streams.
- Round-robin arbiter grants one requester per frame, clears the sorter, forwards that requester's samples, and waits for the array to settle.
- Holds the sorted result, tagged with owner and count, until the consumer acknowledges. The consumer reads the Sorter DO directly.

---
 rtl/sort_pkg.sv | 24 ++
 rtl/sorter_scheduler_rr_arbiter.sv | 33 +++
 rtl/sorter_scheduler.sv | 155 +++++++++++++++
 tb/tb_sorter_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the insertion sorter and its frame scheduler.
package sort_pkg;

    localparam int DEF_WID = 9;
    localparam int DEF_DEP = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FILL,
        S_SETTLE,
        S_HOLD
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sorter_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first active request at or after ptr, wrapping modulo NREQ.
module rr_arbiter
    import sort_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [IW:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = (IW+1)'(ptr) + (IW+1)'(i);
            if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
            if (!any && req[cand[IW-1:0]]) begin
                any = 1'b1;
                idx = cand[IW-1:0];
            end
        end
        if (any) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/sorter_scheduler.sv
// Time-shares one insertion sorter between NREQ frame requesters and holds each sorted result
// until the consumer acknowledges it.
//
// state    | meaning
// S_IDLE   | arbitrate among REQ, register one-hot GNT
// S_CLEAR  | one-cycle SORT_RST pulse, push count and overflow cleared
// S_FILL   | forward granted samples until LAST or REQ drop
// S_SETTLE | down-count SETTLE cycles for the array to settle
// S_HOLD   | result stable on the sorter output until RES_ACK
module sorter_scheduler
    import sort_pkg::*;
#(
    parameter int WID    = DEF_WID,
    parameter int DEP    = DEF_DEP,
    parameter int NREQ   = 4,
    parameter int SETTLE = 2,
    localparam int IW    = (clog2(NREQ) < 1) ? 1 : clog2(NREQ)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NREQ-1:0]     REQ,
    input  logic [NREQ*WID-1:0] REQ_DIN,
    input  logic [NREQ-1:0]     REQ_VALID,
    input  logic [NREQ-1:0]     REQ_LAST,
    output logic [NREQ-1:0]     GNT,
    output logic                SORT_RST,
    output logic [WID-1:0]      SORT_DIN,
    output logic                SORT_VALID,
    input  logic [7:0]          SORT_NCELLS,
    output logic                RES_READY,
    output logic [IW-1:0]       RES_OWNER,
    output logic [7:0]          RES_COUNT,
    output logic                RES_ERR,
    input  logic                RES_ACK
);

    localparam logic [7:0] DEP8    = 8'(DEP);
    localparam logic [3:0] SETTLE4 = 4'(SETTLE);

    state_t          state, state_nxt;
    logic [IW-1:0]   gidx, ptr;
    logic [7:0]      count;
    logic            ovf;
    logic [3:0]      settle_cnt;
    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;
    logic            take, push, frame_end;
    logic            req_g, valid_g, last_g;
    logic [WID-1:0]  din_g;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req (REQ),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign req_g   = REQ[gidx];
    assign valid_g = REQ_VALID[gidx];
    assign last_g  = REQ_LAST[gidx];
    assign din_g   = REQ_DIN[gidx*WID +: WID];

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] g);
        return (g == IW'(NREQ - 1)) ? '0 : g + 1'b1;
    endfunction

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        push      = 1'b0;
        frame_end = 1'b0;
        case (state)
            S_IDLE:   if (arb_any) state_nxt = S_CLEAR;
            S_CLEAR:  state_nxt = S_FILL;
            S_FILL: begin
                // A REQ drop ends the frame without taking a coincident sample.
                if (!req_g) begin
                    frame_end = 1'b1;
                end else if (valid_g) begin
                    take      = 1'b1;
                    push      = (count < DEP8);
                    frame_end = last_g;
                end
                if (frame_end) state_nxt = (count != 8'd0 || push) ? S_SETTLE : S_IDLE;
            end
            S_SETTLE: if (settle_cnt == 4'd0) state_nxt = S_HOLD;
            S_HOLD:   if (RES_ACK) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            GNT        <= '0;
            gidx       <= '0;
            ptr        <= '0;
            count      <= '0;
            ovf        <= 1'b0;
            settle_cnt <= '0;
            SORT_RST   <= 1'b0;
            SORT_DIN   <= '0;
            SORT_VALID <= 1'b0;
            RES_READY  <= 1'b0;
            RES_OWNER  <= '0;
            RES_COUNT  <= '0;
            RES_ERR    <= 1'b0;
        end else begin
            SORT_RST   <= (state == S_IDLE) && arb_any;
            SORT_VALID <= push;
            if (push) begin
                SORT_DIN <= din_g;
                count    <= count + 8'd1;
            end
            if (take && !push) ovf <= 1'b1;
            case (state)
                S_IDLE: if (arb_any) begin
                    GNT  <= arb_gnt;
                    gidx <= arb_idx;
                end
                S_CLEAR: begin
                    count <= '0;
                    ovf   <= 1'b0;
                end
                S_FILL: if (frame_end) begin
                    GNT        <= '0;
                    settle_cnt <= SETTLE4;
                    if (state_nxt == S_IDLE) ptr <= wrap_inc(gidx);
                end
                S_SETTLE: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end else begin
                        RES_READY <= 1'b1;
                        RES_OWNER <= gidx;
                        RES_COUNT <= count;
                        RES_ERR   <= ovf || (SORT_NCELLS != count);
                    end
                end
                S_HOLD: if (RES_ACK) begin
                    RES_READY <= 1'b0;
                    ptr       <= wrap_inc(gidx);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sorter_scheduler.sv
// Self-checking bench for sorter_scheduler with a behavioural sorter and arbitration model.
module tb_sorter_scheduler;
    import sort_pkg::*;

    localparam int WID = 9, DEP = 11, NREQ = 4, SETTLE = 2, IW = 2;

    typedef int iq_t[$];

    logic                CLK = 1'b0;
    logic                RST = 1'b0;
    logic [NREQ-1:0]     REQ = '0, REQ_VALID = '0, REQ_LAST = '0;
    logic [NREQ*WID-1:0] REQ_DIN = '0;
    logic [NREQ-1:0]     GNT;
    logic                SORT_RST, SORT_VALID;
    logic [WID-1:0]      SORT_DIN;
    logic [7:0]          SORT_NCELLS;
    logic                RES_READY;
    logic [IW-1:0]       RES_OWNER;
    logic [7:0]          RES_COUNT;
    logic                RES_ERR;
    logic                RES_ACK = 1'b0;

    int errors = 0, checks = 0;
    int rst_pulses = 0, valid_pulses = 0, gnt_multi = 0;
    int cells[$];
    int frame_q[$], obs_valid[$], obs_din[$];
    int to_flag = 0, ack_in_fill = 0, model_ptr = 0;

    sorter_scheduler #(.WID(WID), .DEP(DEP), .NREQ(NREQ), .SETTLE(SETTLE)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_DIN(REQ_DIN), .REQ_VALID(REQ_VALID),
        .REQ_LAST(REQ_LAST), .GNT(GNT), .SORT_RST(SORT_RST), .SORT_DIN(SORT_DIN),
        .SORT_VALID(SORT_VALID), .SORT_NCELLS(SORT_NCELLS), .RES_READY(RES_READY),
        .RES_OWNER(RES_OWNER), .RES_COUNT(RES_COUNT), .RES_ERR(RES_ERR), .RES_ACK(RES_ACK)
    );

    always #5 CLK = ~CLK;

    // Behavioural sorter: cells kept ascending, cleared only by SORT_RST.
    always @(posedge CLK) begin
        if (SORT_RST) cells.delete();
        else if (SORT_VALID && cells.size() < DEP) begin
            cells.push_back(int'(SORT_DIN));
            cells.sort();
        end
        SORT_NCELLS <= 8'(cells.size());
    end

    always @(negedge CLK) begin
        if (RST) begin
            if (SORT_RST) rst_pulses++;
            if (SORT_VALID) valid_pulses++;
            if ($countones(GNT) > 1) gnt_multi++;
        end
    end

    function automatic iq_t sorted_ref(input int n);
        iq_t q;
        for (int k = 0; k < n && k < DEP; k++) q.push_back(frame_q[k]);
        q.sort();
        return q;
    endfunction

    function automatic bit same_q(input iq_t a, input iq_t b);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[k]) if (a[k] != b[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic make_frame(input int n);
        frame_q.delete();
        for (int k = 0; k < n; k++) frame_q.push_back(int'($urandom_range(0, 511)));
    endtask

    task automatic wait_grant(output int idx);
        int w;
        w = 0;
        while (GNT == '0 && w < 60) begin @(posedge CLK); #1; w++; end
        idx = -1;
        for (int i = 0; i < NREQ; i++) if (GNT[i]) idx = i;
    endtask

    // Waits for the CLEAR cycle of requester r, then streams frame_q with random noise on others.
    task automatic drive_frame(input int r, input int n, input bit do_last, output int lat);
        int w;
        to_flag = 0;
        w = 0;
        while (!(GNT[r] && SORT_RST) && w < 60) begin @(posedge CLK); #1; w++; end
        if (w >= 60) to_flag = 1;
        obs_valid.delete();
        obs_din.delete();
        @(posedge CLK); #1;
        for (int k = 0; k < n; k++) begin
            REQ_DIN[r*WID +: WID] = WID'(frame_q[k]);
            REQ_VALID    = NREQ'($urandom);
            REQ_VALID[r] = 1'b1;
            REQ_LAST     = NREQ'($urandom);
            REQ_LAST[r]  = do_last && (k == n - 1);
            if (ack_in_fill != 0) RES_ACK = 1'b1;
            @(posedge CLK); #1;
            obs_valid.push_back(int'(SORT_VALID));
            obs_din.push_back(int'(SORT_DIN));
        end
        REQ_VALID = '0;
        REQ_LAST  = '0;
        RES_ACK   = 1'b0;
        if (!do_last) begin
            REQ[r] = 1'b0;
            @(posedge CLK); #1;
        end
        lat = 0;
        while (!RES_READY && lat < 20) begin @(posedge CLK); #1; lat++; end
        if (!RES_READY) lat = -1;
    endtask

    task automatic do_ack;
        @(posedge CLK); #1;
        RES_ACK = 1'b1;
        @(posedge CLK); #1;
        RES_ACK = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (GNT !== '0) begin errors++; $display("FAIL reset_gnt: got %b want 0", GNT); end
        checks++; if (SORT_RST !== 1'b0) begin errors++; $display("FAIL reset_sort_rst: got %b want 0", SORT_RST); end
        checks++; if (SORT_VALID !== 1'b0) begin errors++; $display("FAIL reset_sort_valid: got %b want 0", SORT_VALID); end
        checks++; if (SORT_DIN !== '0) begin errors++; $display("FAIL reset_sort_din: got %0d want 0", SORT_DIN); end
        checks++; if (RES_READY !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", RES_READY); end
        checks++; if (RES_OWNER !== '0) begin errors++; $display("FAIL reset_owner: got %0d want 0", RES_OWNER); end
        checks++; if (RES_COUNT !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", RES_COUNT); end
        checks++; if (RES_ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", RES_ERR); end
        RST = 1'b1;
        model_ptr = 0;
        @(posedge CLK); #1;
    endtask

    task automatic test_single_frame;
        int lat, r0, v0, din_bad;
        iq_t exp_q;
        frame_q = '{55, 10, 77, 1, 60, 10, 255};
        exp_q   = '{1, 10, 10, 55, 60, 77, 255};
        r0 = rst_pulses;
        v0 = valid_pulses;
        REQ[0] = 1'b1;
        drive_frame(0, 7, 1'b1, lat);
        REQ[0] = 1'b0;
        din_bad = 0;
        for (int k = 0; k < 7; k++) if (obs_valid[k] != 1 || obs_din[k] != frame_q[k]) din_bad++;
        checks++; if (to_flag != 0) begin errors++; $display("FAIL single_grant_timeout: got %0d want 0", to_flag); end
        checks++; if (rst_pulses - r0 != 1) begin errors++; $display("FAIL single_sort_rst_pulses: got %0d want 1", rst_pulses - r0); end
        checks++; if (valid_pulses - v0 != 7) begin errors++; $display("FAIL single_valid_pulses: got %0d want 7", valid_pulses - v0); end
        checks++; if (din_bad != 0) begin errors++; $display("FAIL single_push_stream: got %0d bad pushes want 0", din_bad); end
        checks++; if (lat != SETTLE + 1) begin errors++; $display("FAIL single_ready_latency: got %0d want %0d", lat, SETTLE + 1); end
        checks++; if (RES_OWNER !== 2'd0) begin errors++; $display("FAIL single_owner: got %0d want 0", RES_OWNER); end
        checks++; if (RES_COUNT !== 8'd7) begin errors++; $display("FAIL single_count: got %0d want 7", RES_COUNT); end
        checks++; if (RES_ERR !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", RES_ERR); end
        checks++; if (!same_q(cells, exp_q)) begin errors++; $display("FAIL single_sorted: got %p want %p", cells, exp_q); end
        do_ack();
        checks++; if (RES_READY !== 1'b0) begin errors++; $display("FAIL single_ack_release: got %b want 0", RES_READY); end
        model_ptr = 1;
    endtask

    task automatic test_round_robin;
        int g, lat;
        RST = 1'b0;
        #2;
        RST = 1'b1;
        model_ptr = 0;
        REQ = '1;
        for (int f = 0; f < 5; f++) begin
            wait_grant(g);
            checks++; if (g != model_ptr) begin errors++; $display("FAIL rr_grant_%0d: got %0d want %0d", f, g, model_ptr); end
            if (g < 0) break;
            make_frame(2);
            drive_frame(g, 2, 1'b1, lat);
            checks++;
            if (lat < 0 || RES_OWNER !== IW'(model_ptr) || RES_COUNT !== 8'd2 || RES_ERR !== 1'b0) begin
                errors++;
                $display("FAIL rr_result_%0d: got lat=%0d owner=%0d count=%0d err=%b want owner=%0d count=2 err=0",
                         f, lat, RES_OWNER, RES_COUNT, RES_ERR, model_ptr);
            end
            checks++; if (!same_q(cells, sorted_ref(2))) begin errors++; $display("FAIL rr_sorted_%0d: got %p want %p", f, cells, sorted_ref(2)); end
            do_ack();
            model_ptr = (model_ptr + 1) % NREQ;
        end
        REQ = '0;
        checks++; if (gnt_multi != 0) begin errors++; $display("FAIL rr_onehot: got %0d multi-grant cycles want 0", gnt_multi); end
    endtask

    task automatic test_overflow;
        int lat, v0, nv;
        REQ = 4'b0100;
        make_frame(14);
        v0 = valid_pulses;
        drive_frame(2, 14, 1'b1, lat);
        REQ = '0;
        nv = 0;
        foreach (obs_valid[k]) nv += obs_valid[k];
        checks++; if (valid_pulses - v0 != DEP) begin errors++; $display("FAIL ovf_valid_pulses: got %0d want %0d", valid_pulses - v0, DEP); end
        checks++; if (nv != DEP || obs_valid[DEP-1] != 1 || obs_valid[DEP] != 0) begin errors++; $display("FAIL ovf_push_window: got %0d pushes want first %0d only", nv, DEP); end
        checks++; if (lat != SETTLE + 1) begin errors++; $display("FAIL ovf_latency: got %0d want %0d", lat, SETTLE + 1); end
        checks++; if (RES_COUNT !== 8'(DEP)) begin errors++; $display("FAIL ovf_count: got %0d want %0d", RES_COUNT, DEP); end
        checks++; if (RES_ERR !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b want 1", RES_ERR); end
        checks++; if (RES_OWNER !== 2'd2) begin errors++; $display("FAIL ovf_owner: got %0d want 2", RES_OWNER); end
        checks++; if (!same_q(cells, sorted_ref(14))) begin errors++; $display("FAIL ovf_sorted: got %p want %p", cells, sorted_ref(14)); end
        do_ack();
        model_ptr = 3;
    endtask

    task automatic test_abort;
        int lat, g;
        REQ = 4'b0010;
        drive_frame(1, 0, 1'b0, lat);
        checks++; if (to_flag != 0) begin errors++; $display("FAIL abort0_grant_timeout: got %0d want 0", to_flag); end
        checks++; if (lat != -1) begin errors++; $display("FAIL abort0_no_result: got ready after %0d cycles want none", lat); end
        REQ = 4'b0110;
        wait_grant(g);
        checks++; if (g != 2) begin errors++; $display("FAIL abort0_ptr_advance: got grant %0d want 2", g); end
        make_frame(1);
        drive_frame(2, 1, 1'b1, lat);
        REQ = 4'b0010;
        do_ack();
        make_frame(3);
        drive_frame(1, 3, 1'b0, lat);
        checks++; if (lat < 0) begin errors++; $display("FAIL abort3_ready: got timeout want result"); end
        checks++; if (RES_COUNT !== 8'd3 || RES_ERR !== 1'b0 || RES_OWNER !== 2'd1) begin
            errors++;
            $display("FAIL abort3_result: got count=%0d err=%b owner=%0d want 3 0 1", RES_COUNT, RES_ERR, RES_OWNER);
        end
        checks++; if (!same_q(cells, sorted_ref(3))) begin errors++; $display("FAIL abort3_sorted: got %p want %p", cells, sorted_ref(3)); end
        do_ack();
        model_ptr = 2;
    endtask

    task automatic test_hold_ack;
        int lat, bad, g;
        REQ = 4'b0001;
        make_frame(2);
        drive_frame(0, 2, 1'b1, lat);
        REQ = 4'b1110;
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            REQ_VALID = NREQ'($urandom);
            @(posedge CLK); #1;
            if (GNT !== '0 || SORT_VALID !== 1'b0 || SORT_RST !== 1'b0 || RES_READY !== 1'b1 ||
                RES_OWNER !== 2'd0 || RES_COUNT !== 8'd2 || RES_ERR !== 1'b0) bad++;
        end
        REQ_VALID = '0;
        checks++; if (bad != 0) begin errors++; $display("FAIL hold_stable: got %0d disturbed cycles want 0", bad); end
        do_ack();
        wait_grant(g);
        checks++; if (g != 1) begin errors++; $display("FAIL hold_next_grant: got %0d want 1", g); end
        ack_in_fill = 1;
        make_frame(4);
        drive_frame(1, 4, 1'b1, lat);
        ack_in_fill = 0;
        checks++; if (lat != SETTLE + 1 || RES_COUNT !== 8'd4 || RES_OWNER !== 2'd1 || RES_ERR !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack_fill: got lat=%0d count=%0d owner=%0d err=%b want %0d 4 1 0",
                     lat, RES_COUNT, RES_OWNER, RES_ERR, SETTLE + 1);
        end
        REQ = '0;
        do_ack();
        model_ptr = 2;
    endtask

    task automatic test_reset_mid_fill;
        int w, lat, r0;
        REQ = 4'b0001;
        w = 0;
        while (!(GNT[0] && SORT_RST) && w < 60) begin @(posedge CLK); #1; w++; end
        @(posedge CLK); #1;
        for (int k = 0; k < 5; k++) begin
            REQ_DIN[0 +: WID] = WID'($urandom_range(0, 511));
            REQ_VALID[0] = 1'b1;
            if (k < 4) begin @(posedge CLK); #1; end
        end
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if ({GNT, SORT_RST, SORT_VALID, SORT_DIN, RES_READY, RES_OWNER, RES_COUNT, RES_ERR} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got gnt=%b rst=%b valid=%b din=%0d ready=%b owner=%0d count=%0d err=%b want all 0",
                     GNT, SORT_RST, SORT_VALID, SORT_DIN, RES_READY, RES_OWNER, RES_COUNT, RES_ERR);
        end
        REQ_VALID = '0;
        @(posedge CLK); #1;
        RST = 1'b1;
        r0 = rst_pulses;
        make_frame(3);
        drive_frame(0, 3, 1'b1, lat);
        REQ = '0;
        checks++; if (to_flag != 0 || rst_pulses - r0 != 1) begin errors++; $display("FAIL midreset_clear: got timeout=%0d pulses=%0d want 0 1", to_flag, rst_pulses - r0); end
        checks++; if (RES_COUNT !== 8'd3 || RES_ERR !== 1'b0 || RES_OWNER !== 2'd0) begin
            errors++;
            $display("FAIL midreset_result: got count=%0d err=%b owner=%0d want 3 0 0", RES_COUNT, RES_ERR, RES_OWNER);
        end
        checks++; if (!same_q(cells, sorted_ref(3))) begin errors++; $display("FAIL midreset_sorted: got %p want %p", cells, sorted_ref(3)); end
        do_ack();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_overflow();
        test_abort();
        test_hold_ack();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
